// File: rtl/io_periph_if.sv
// ---------------------------------------------------------------------------
// io_periph_if
//  CPU IO-port bus between the single-cycle CPU (master) and the memory-mapped
//  IO responder (slave).
//  Signals:
//   ioCe      CPU -> dev  IO access enable
//   ioWe      CPU -> dev  write strobe, meaningful only with ioCe=1
//   ioAddr    CPU -> dev  byte address, bits [1:0] ignored by the device
//   ioWtData  CPU -> dev  write data
//   ioRdData  dev -> CPU  combinational read data
// ---------------------------------------------------------------------------
interface io_periph_if;
   logic        ioCe;
   logic        ioWe;
   logic [31:0] ioAddr;
   logic [31:0] ioWtData;
   logic [31:0] ioRdData;

   modport master (output ioCe, output ioWe, output ioAddr, output ioWtData,
                   input  ioRdData);
   modport slave  (input  ioCe, input  ioWe, input  ioAddr, input  ioWtData,
                   output ioRdData);
endinterface

// File: rtl/io_periph.sv
// ---------------------------------------------------------------------------
// io_periph
//  Memory-mapped IO responder: LED, switch, timer and UART-TX registers in a
//  10-word window starting at BASE_ADDR. Reads are combinational, writes
//  commit on the rising clock edge.
//  Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       CPU IO bus (slave side)
//   sw        raw switches, asynchronous (2-flop synchronised)
//   led       LED drive
//   txd       UART serial out, idles high
//   timerIrq  timer interrupt, level
// ---------------------------------------------------------------------------
module io_periph #(
   parameter logic [31:0] BASE_ADDR        = 32'h0000_1000,
   parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434,
   parameter int          LED_W            = 16,
   parameter int          SW_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   io_periph_if.slave       bus,
   input  logic [SW_W-1:0]  sw,
   output logic [LED_W-1:0] led,
   output logic             txd,
   output logic             timerIrq
);

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

   // Address decode. The unsigned subtract wraps addresses below the base to
   // huge values, so a single compare covers both ends of the window.
   logic [31:0] offset;
   logic        in_range;
   logic [3:0]  idx;
   logic        wr_en;

   assign offset   = bus.ioAddr - BASE_ADDR;
   assign in_range = (offset < 32'h28);
   assign idx      = offset[5:2];
   assign wr_en    = bus.ioCe & bus.ioWe & in_range;

   logic wr_led, wr_count, wr_cmp, wr_ctrl, wr_tstat, wr_tx, wr_ustat, wr_baud, wr_scratch;
   assign wr_led     = wr_en && (idx == 4'd0);
   assign wr_count   = wr_en && (idx == 4'd2);
   assign wr_cmp     = wr_en && (idx == 4'd3);
   assign wr_ctrl    = wr_en && (idx == 4'd4);
   assign wr_tstat   = wr_en && (idx == 4'd5);
   assign wr_tx      = wr_en && (idx == 4'd6);
   assign wr_ustat   = wr_en && (idx == 4'd7);
   assign wr_baud    = wr_en && (idx == 4'd8);
   assign wr_scratch = wr_en && (idx == 4'd9);

   logic [SW_W-1:0] sw_s1, sw_s2;
   logic [31:0]     count, cmp, scratch;
   logic [2:0]      ctrl;          // [0]en [1]autoReload [2]irqEn
   logic            irq_flag, overrun;
   logic [15:0]     baud;
   logic            cmp_hit;

   assign cmp_hit  = ctrl[0] && (count == cmp);
   assign timerIrq = irq_flag & ctrl[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led      <= '0;
         sw_s1    <= '0;
         sw_s2    <= '0;
         count    <= '0;
         cmp      <= '0;
         ctrl     <= '0;
         irq_flag <= 1'b0;
         baud     <= DEFAULT_BAUD_DIV;
         scratch  <= '0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         if (wr_led)     led     <= bus.ioWtData[LED_W-1:0];
         if (wr_cmp)     cmp     <= bus.ioWtData;
         if (wr_ctrl)    ctrl    <= bus.ioWtData[2:0];
         if (wr_baud)    baud    <= bus.ioWtData[15:0];
         if (wr_scratch) scratch <= bus.ioWtData;
         // A CPU write to COUNT wins over both increment and reload.
         if (wr_count)
            count <= bus.ioWtData;
         else if (ctrl[0])
            count <= (cmp_hit && ctrl[1]) ? 32'd0 : count + 32'd1;
         // A compare hit beats a simultaneous W1C clear.
         if (cmp_hit)
            irq_flag <= 1'b1;
         else if (wr_tstat && bus.ioWtData[0])
            irq_flag <= 1'b0;
      end
   end

   // UART transmitter
   uart_state_t state, state_nxt;
   logic [15:0] div, div_nxt, cnt, cnt_nxt;
   logic [7:0]  sh, sh_nxt;
   logic [2:0]  bitn, bitn_nxt;
   logic        bit_end, busy;

   assign busy    = (state != U_IDLE);
   assign bit_end = (cnt == div - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= U_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      bitn_nxt  = bitn;
      case (state)
         U_IDLE: begin
            if (wr_tx) begin
               sh_nxt    = bus.ioWtData[7:0];
               // Divider is captured here so a later BAUD write cannot
               // stretch or shrink the frame in flight.
               div_nxt   = (baud == 16'd0) ? 16'd1 : baud;
               cnt_nxt   = 16'd0;
               state_nxt = U_START;
            end
         end
         U_START: begin
            cnt_nxt = cnt + 16'd1;
            if (bit_end) begin
               cnt_nxt   = 16'd0;
               bitn_nxt  = 3'd0;
               state_nxt = U_DATA;
            end
         end
         U_DATA: begin
            cnt_nxt = cnt + 16'd1;
            if (bit_end) begin
               cnt_nxt  = 16'd0;
               sh_nxt   = {1'b0, sh[7:1]};
               bitn_nxt = bitn + 3'd1;
               if (bitn == 3'd7) state_nxt = U_STOP;
            end
         end
         U_STOP: begin
            cnt_nxt = cnt + 16'd1;
            if (bit_end) begin
               cnt_nxt   = 16'd0;
               state_nxt = U_IDLE;
            end
         end
         default: state_nxt = U_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div     <= 16'd1;
         cnt     <= '0;
         sh      <= '0;
         bitn    <= '0;
         overrun <= 1'b0;
      end else begin
         div  <= div_nxt;
         cnt  <= cnt_nxt;
         sh   <= sh_nxt;
         bitn <= bitn_nxt;
         if (wr_tx && busy)
            overrun <= 1'b1;
         else if (wr_ustat && bus.ioWtData[1])
            overrun <= 1'b0;
      end
   end

   // txd is decoded from the async-reset state, so reset forces it high at once.
   always_comb begin
      case (state)
         U_START: txd = 1'b0;
         U_DATA:  txd = sh[0];
         default: txd = 1'b1;
      endcase
   end

   // Combinational read mux
   always_comb begin
      bus.ioRdData = 32'd0;
      if (bus.ioCe && in_range) begin
         case (idx)
            4'd0:    bus.ioRdData = 32'(led);
            4'd1:    bus.ioRdData = 32'(sw_s2);
            4'd2:    bus.ioRdData = count;
            4'd3:    bus.ioRdData = cmp;
            4'd4:    bus.ioRdData = {29'd0, ctrl};
            4'd5:    bus.ioRdData = {31'd0, irq_flag};
            4'd7:    bus.ioRdData = {30'd0, overrun, busy};
            4'd8:    bus.ioRdData = {16'd0, baud};
            4'd9:    bus.ioRdData = scratch;
            default: bus.ioRdData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_periph.sv
// ---------------------------------------------------------------------------
// tb_io_periph
//  Self-checking bench for io_periph: expected values are queued when
//  stimulus is applied and popped when the matching DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_io_periph;

   localparam logic [31:0] A_LED   = 32'h1000, A_SW    = 32'h1004, A_COUNT = 32'h1008,
                           A_CMP   = 32'h100C, A_CTRL  = 32'h1010, A_TSTAT = 32'h1014,
                           A_TX    = 32'h1018, A_USTAT = 32'h101C, A_BAUD  = 32'h1020,
                           A_SCR   = 32'h1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sw = '0;
   logic [15:0] led;
   logic        txd, timerIrq;

   io_periph_if bus ();

   io_periph dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .sw       (sw),
      .led      (led),
      .txd      (txd),
      .timerIrq (timerIrq)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic        tb_ovr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic observe(input string tag, input logic [31:0] obs);
      if (exp_q.size() == 0) check({tag, "_noexp"}, obs, ~obs);
      else                   check(tag, obs, exp_q.pop_front());
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.ioCe = 1'b1; bus.ioWe = 1'b1; bus.ioAddr = addr; bus.ioWtData = data;
      @(posedge clk); #1;
      bus.ioCe = 1'b0; bus.ioWe = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.ioCe = 1'b1; bus.ioWe = 1'b0; bus.ioAddr = addr;
      #1;
      expect_val(exp);
      observe(tag, bus.ioRdData);
      bus.ioCe = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Sends one byte and follows the line bit-cell by bit-cell. Optionally
   // injects a TXDATA write (cycle ovr_k) and a BAUD write (cycle baud_k).
   task automatic frame(input logic [7:0] b, input int div, input int ovr_k,
                        input int baud_k, input logic [15:0] baud_new);
      int bi;
      wr(A_TX, {24'd0, b});
      for (int k = 0; k < 10 * div; k++) begin
         bi = k / div;
         expect_val((bi == 0) ? 32'd0 : (bi == 9) ? 32'd1 : {31'd0, b[bi-1]});
         observe("txd_bit", {31'd0, txd});
         bus.ioCe = 1'b1; bus.ioWe = 1'b0; bus.ioAddr = A_USTAT;
         #1;
         expect_val(tb_ovr ? 32'd3 : 32'd1);
         observe("ustat_busy", bus.ioRdData);
         if (k == ovr_k) begin
            bus.ioWe = 1'b1; bus.ioAddr = A_TX; bus.ioWtData = {24'd0, ~b};
         end else if (k == baud_k) begin
            bus.ioWe = 1'b1; bus.ioAddr = A_BAUD; bus.ioWtData = {16'd0, baud_new};
         end else begin
            bus.ioCe = 1'b0;
         end
         @(posedge clk); #1;
         bus.ioCe = 1'b0; bus.ioWe = 1'b0;
         if (k == ovr_k) tb_ovr = 1'b1;
      end
      expect_val(32'd1);
      observe("txd_idle", {31'd0, txd});
      rd("ustat_end", A_USTAT, tb_ovr ? 32'd2 : 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ioCe = 1'b0; bus.ioWe = 1'b0; bus.ioAddr = '0; bus.ioWtData = '0;
      #23 rst_n = 1'b1;
      tick();

      // 1. reset state
      rd("baud_rst", A_BAUD, 32'd434);
      rd("led_rst", A_LED, 32'd0);
      rd("count_rst", A_COUNT, 32'd0);
      rd("ustat_rst", A_USTAT, 32'd0);
      expect_val(32'd1); observe("txd_rst", {31'd0, txd});
      expect_val(32'd0); observe("irq_rst", {31'd0, timerIrq});

      // 2. LED, out-of-range, ioCe gating, scratch
      wr(A_LED, 32'h0000_A5A5);
      expect_val(32'hA5A5); observe("led_pin", {16'd0, led});
      rd("oor_hi", 32'h1028, 32'd0);
      rd("oor_lo", 32'h0FFC, 32'd0);
      wr(32'h1028, 32'hFFFF_FFFF);
      wr(32'h0FFC, 32'hFFFF_FFFF);
      rd("led_keep", A_LED, 32'hA5A5);
      rd("scr_keep", A_SCR, 32'd0);
      wr(A_SCR, 32'h1234_5678);
      rd("scr_rw", A_SCR, 32'h1234_5678);
      rd("tx_reads0", A_TX, 32'd0);
      bus.ioAddr = A_LED; #1;
      expect_val(32'd0); observe("ce_off", bus.ioRdData);

      // 3. timer compare, auto-reload, irq, W1C
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'd7);
      for (int i = 1; i <= 6; i++) begin
         tick();
         expect_val((i == 6) ? 32'd1 : 32'd0);
         observe("irq_rise", {31'd0, timerIrq});
      end
      rd("count_reload", A_COUNT, 32'd0);
      wr(A_CTRL, 32'd4);
      rd("ctrl_rd", A_CTRL, 32'd4);
      rd("tstat_set", A_TSTAT, 32'd1);
      wr(A_TSTAT, 32'd0);
      expect_val(32'd1); observe("irq_w0", {31'd0, timerIrq});
      wr(A_TSTAT, 32'd1);
      expect_val(32'd0); observe("irq_w1c", {31'd0, timerIrq});
      rd("tstat_clr", A_TSTAT, 32'd0);
      wr(A_CTRL, 32'd1);
      wr(A_COUNT, 32'd100);
      rd("count_ovr", A_COUNT, 32'd100);
      tick();
      rd("count_inc", A_COUNT, 32'd101);
      wr(A_COUNT, 32'hFFFF_FFFF);
      rd("count_max", A_COUNT, 32'hFFFF_FFFF);
      tick();
      rd("count_wrap", A_COUNT, 32'd0);
      wr(A_CTRL, 32'd0);

      // 4. UART frame at BAUD=4
      wr(A_BAUD, 32'd4);
      frame(8'h53, 4, -1, -1, 16'd0);
      // 5. overrun during frame plus BAUD change mid-frame
      frame(8'h53, 4, 10, 20, 16'd2);
      wr(A_USTAT, 32'd2);
      tb_ovr = 1'b0;
      rd("ovr_clr", A_USTAT, 32'd0);
      frame(8'h3C, 2, -1, -1, 16'd0);
      wr(A_BAUD, 32'd0);
      frame(8'hA0, 1, -1, -1, 16'd0);

      // 6. async reset mid-frame, switch sync
      wr(A_BAUD, 32'd4);
      wr(A_TX, 32'h0000_00FF);
      tick();
      expect_val(32'd0); observe("txd_start", {31'd0, txd});
      #2 rst_n = 1'b0;
      #1;
      expect_val(32'd1); observe("txd_async", {31'd0, txd});
      rd("busy_async", A_USTAT, 32'd0);
      rd("led_async", A_LED, 32'd0);
      rd("baud_async", A_BAUD, 32'd434);
      tick();
      rst_n = 1'b1;
      tick();
      sw = 16'h1234;
      tick();
      rd("sw_1cyc", A_SW, 32'd0);
      tick();
      rd("sw_2cyc", A_SW, 32'h1234);
      expect_val(32'd1); observe("txd_post", {31'd0, txd});

      if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
